// File: rtl/pipeline_load_control_if.sv
// Handshake and load/flush bundle between the pipeline load controller and the pipeline datapath.
// The master side is the controller; the slave side is the datapath and memory ports.
interface pipeline_load_control_if #(
  parameter int unsigned CNT_W = 16
);
  logic             imem_resp;
  logic             dmem_req;
  logic             dmem_resp;
  logic             load_use_hazard;
  logic             branch_taken;
  logic             imem_read;
  logic             dmem_go;
  logic             load_pc;
  logic             load_if_id;
  logic             load_id_ex;
  logic             load_ex_mem;
  logic             load_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic [CNT_W-1:0] stall_count;

  modport master (
    input  imem_resp, dmem_req, dmem_resp, load_use_hazard, branch_taken,
    output imem_read, dmem_go, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, stall_count
  );

  modport slave (
    output imem_resp, dmem_req, dmem_resp, load_use_hazard, branch_taken,
    input  imem_read, dmem_go, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, stall_count
  );
endinterface

// File: rtl/pipeline_load_control.sv
// Pipeline load/flush controller: advances only when fetch and data access have both completed,
// remembering an early-completed response so its port is not re-requested.
module pipeline_load_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_load_control_if.master bus
);

  typedef enum logic [1:0] {StRun, StIDone, StDDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             i_ok, d_ok, advance;

  always_comb begin
    i_ok    = bus.imem_resp | (state_q == StIDone);
    d_ok    = ~bus.dmem_req | bus.dmem_resp | (state_q == StDDone);
    advance = i_ok & d_ok & ~reset;

    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (advance)                            state_d = StRun;
        else if (bus.imem_resp)                 state_d = StIDone;
        else if (bus.dmem_req && bus.dmem_resp) state_d = StDDone;
        else                                    state_d = StRun;
      end
      StIDone: if (d_ok) state_d = StRun;
      StDDone: if (bus.imem_resp) state_d = StRun;
      default: state_d = StRun;
    endcase

    // Saturating stall counter; frozen while reset is high.
    cnt_d = cnt_q;
    if (!reset && !advance && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.imem_read    = ~reset & (state_q != StIDone);
    bus.dmem_go      = ~reset & bus.dmem_req & (state_q != StDDone);
    bus.load_pc      = 1'b0;
    bus.load_if_id   = 1'b0;
    bus.load_id_ex   = 1'b0;
    bus.load_ex_mem  = 1'b0;
    bus.load_mem_wb  = 1'b0;
    bus.flush_if_id  = 1'b0;
    bus.flush_id_ex  = 1'b0;
    bus.flush_ex_mem = 1'b0;
    bus.stall_count  = cnt_q;

    if (advance) begin
      bus.load_id_ex  = 1'b1;
      bus.load_ex_mem = 1'b1;
      bus.load_mem_wb = 1'b1;
      if (bus.branch_taken) begin
        bus.load_pc      = 1'b1;
        bus.load_if_id   = 1'b1;
        bus.flush_if_id  = 1'b1;
        bus.flush_id_ex  = 1'b1;
        bus.flush_ex_mem = 1'b1;
      end else if (bus.load_use_hazard) begin
        // Hold PC and IF/ID so the fetched word is refetched; bubble into ID/EX.
        bus.flush_id_ex = 1'b1;
      end else begin
        bus.load_pc    = 1'b1;
        bus.load_if_id = 1'b1;
      end
    end
  end

endmodule
